// File: rtl/mem_arb_pkg.sv
// Shared encodings and helpers for the IF/MEM single-port RAM arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

    // Wide enough for RAM_LAT up to 4 and STARVE_MAX up to 15.
    localparam int LAT_CNT_W    = 2;
    localparam int STARVE_CNT_W = 4;

    function automatic logic [LAT_CNT_W-1:0] lat_load(input int ram_lat);
        return LAT_CNT_W'(ram_lat - 1);
    endfunction

endpackage

// File: rtl/arb_pick.sv
// Grant priority between the IF and data ports, with a data-grant starvation
// counter that forces an IF grant after STARVE_MAX back-to-back data grants.
module arb_pick
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic if_req,
    input  logic d_req,
    input  logic if_ready,
    input  logic d_ready,
    input  logic grant_evt,
    output logic grant_if,
    output logic grant_d
);

    logic [STARVE_CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic                    if_elig;
    logic                    d_elig;
    logic                    starved;

    // A port completing this cycle must not be granted again on the same request.
    assign if_elig = if_req & ~if_ready;
    assign d_elig  = d_req & ~d_ready;
    assign starved = (starve_cnt_q == STARVE_CNT_W'(STARVE_MAX));

    always_comb begin
        grant_if = 1'b0;
        grant_d  = 1'b0;
        if (if_elig && d_elig) begin
            grant_if = starved;
            grant_d  = ~starved;
        end else begin
            grant_if = if_elig;
            grant_d  = d_elig;
        end
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (grant_evt) begin
            if (grant_d && if_req) begin
                if (!starved) begin
                    starve_cnt_d = starve_cnt_q + 1'b1;
                end
            end else begin
                starve_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous RAM between the IF and MEM ports: arbitrates,
// sequences each access through the RAM read latency and returns a ready pulse.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int RAM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              busy
);

    arb_state_e           state_q, state_d;
    owner_e               owner_q, owner_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic                 we_q, we_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic [LAT_CNT_W-1:0] lat_cnt_q, lat_cnt_d;
    logic [DATA_W-1:0]    if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]    d_rdata_q, d_rdata_d;
    logic                 if_ready_q, if_ready_d;
    logic                 d_ready_q, d_ready_d;

    logic                 grant_if;
    logic                 grant_d;
    logic                 grant_evt;

    assign grant_evt = (state_q == IDLE) && (grant_if || grant_d);

    arb_pick #(
        .STARVE_MAX (STARVE_MAX)
    ) u_pick (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .d_req     (d_req),
        .if_ready  (if_ready_q),
        .d_ready   (d_ready_q),
        .grant_evt (grant_evt),
        .grant_if  (grant_if),
        .grant_d   (grant_d)
    );

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        lat_cnt_d  = lat_cnt_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        if_ready_d = 1'b0;
        d_ready_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant_if) begin
                    owner_d = OWN_IF;
                    addr_d  = if_addr;
                    we_d    = 1'b0;
                    wdata_d = '0;
                    state_d = ISSUE;
                end else if (grant_d) begin
                    owner_d = OWN_D;
                    addr_d  = d_addr;
                    we_d    = d_we;
                    wdata_d = d_wdata;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (we_q) begin
                    state_d = DONE;
                end else begin
                    lat_cnt_d = lat_load(RAM_LAT);
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (lat_cnt_q == '0) begin
                    if (owner_q == OWN_IF) begin
                        if_rdata_d = ram_rdata;
                    end else begin
                        d_rdata_d = ram_rdata;
                    end
                    state_d = DONE;
                end else begin
                    lat_cnt_d = lat_cnt_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // DONE is only ever entered from ISSUE or WAIT, so this is a one-cycle pulse.
        if (state_d == DONE) begin
            if_ready_d = (owner_q == OWN_IF);
            d_ready_d  = (owner_q == OWN_D);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            owner_q    <= OWN_IF;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            lat_cnt_q  <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            if_ready_q <= 1'b0;
            d_ready_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            lat_cnt_q  <= lat_cnt_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            if_ready_q <= if_ready_d;
            d_ready_q  <= d_ready_d;
        end
    end

    // The RAM is word-addressed: misaligned byte offsets are silently dropped.
    assign ram_en    = (state_q == ISSUE);
    assign ram_we    = ram_en & we_q;
    assign ram_addr  = addr_q & {{(ADDR_W-2){1'b1}}, 2'b00};
    assign ram_wdata = wdata_q;

    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign if_ready  = if_ready_q;
    assign d_ready   = d_ready_q;
    assign busy      = (state_q != IDLE);
    assign stall_if  = if_req & ~if_ready_q;
    assign stall_mem = d_req & ~d_ready_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// against a cycle-count reference model of the arbitration and access timing.
module tb_mem_arbiter;

    localparam int LAT1 = 1;
    localparam int LAT3 = 3;
    localparam int SMAX = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Main DUT (RAM_LAT = 1)
    logic        if_req, if_ready, d_req, d_we, d_ready;
    logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
    logic        ram_en, ram_we, stall_if, stall_mem, busy;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;

    // Latency-sweep DUT (RAM_LAT = 3)
    logic        if_req3, if_ready3, d_req3, d_we3, d_ready3;
    logic [31:0] if_addr3, if_rdata3, d_addr3, d_wdata3, d_rdata3;
    logic        ram_en3, ram_we3, stall_if3, stall_mem3, busy3;
    logic [31:0] ram_addr3, ram_wdata3, ram_rdata3;

    int checks = 0;
    int errors = 0;

    bit   [31:0] mem1 [16384];
    bit          wr1  [16384];
    logic [31:0] ref_mem [16384];

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RAM_LAT(LAT1), .STARVE_MAX(SMAX)) u_dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .stall_if(stall_if), .stall_mem(stall_mem), .busy(busy)
    );

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RAM_LAT(LAT3), .STARVE_MAX(SMAX)) u_dut3 (
        .clk(clk), .reset(reset),
        .if_req(if_req3), .if_addr(if_addr3), .if_rdata(if_rdata3), .if_ready(if_ready3),
        .d_req(d_req3), .d_we(d_we3), .d_addr(d_addr3), .d_wdata(d_wdata3),
        .d_rdata(d_rdata3), .d_ready(d_ready3),
        .ram_en(ram_en3), .ram_we(ram_we3), .ram_addr(ram_addr3), .ram_wdata(ram_wdata3),
        .ram_rdata(ram_rdata3), .stall_if(stall_if3), .stall_mem(stall_mem3), .busy(busy3)
    );

    function automatic logic [31:0] ram_init(input int idx);
        if (idx == 16) return 32'hDEADBEEF;
        return (idx * 32'h9E37_79B9) ^ 32'h5A5A_1234;
    endfunction

    // RAM for the main DUT: one-cycle read latency, garbage when no read is due.
    always @(posedge clk) begin
        if (ram_en && ram_we) begin
            mem1[ram_addr[15:2]] <= ram_wdata;
            wr1[ram_addr[15:2]]  <= 1'b1;
        end
        if (ram_en && !ram_we)
            ram_rdata <= wr1[ram_addr[15:2]] ? mem1[ram_addr[15:2]] : ram_init(int'(ram_addr[15:2]));
        else
            ram_rdata <= $urandom;
    end

    // RAM for the latency-sweep DUT: three-cycle read latency, address-derived data.
    logic [1:0]  p3_v = '0;
    logic [31:0] p3_d0, p3_d1;
    always @(posedge clk) begin
        p3_v       <= {p3_v[0], ram_en3 & ~ram_we3};
        p3_d0      <= {ram_addr3[15:0], 16'hC0DE};
        p3_d1      <= p3_d0;
        ram_rdata3 <= p3_v[1] ? p3_d1 : $urandom;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        checks++;
        if ({ram_en, ram_we, if_ready, d_ready, busy} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b expected 00000", {ram_en, ram_we, if_ready, d_ready, busy});
        end
        checks++;
        if ({ram_addr, ram_wdata} !== 64'h0) begin
            errors++; $display("FAIL reset_ram_bus: got %h expected 0", {ram_addr, ram_wdata});
        end
        checks++;
        if ({if_rdata, d_rdata} !== 64'h0) begin
            errors++; $display("FAIL reset_rdata: got %h expected 0", {if_rdata, d_rdata});
        end
        reset = 1'b0;
        tick();
        checks++;
        if ({busy, ram_en, stall_if, stall_mem} !== 4'b0) begin
            errors++; $display("FAIL reset_release_idle: got %b expected 0000", {busy, ram_en, stall_if, stall_mem});
        end
    endtask

    task automatic test_if_read();
        tick();
        if_addr = 32'h0040; if_req = 1'b1;
        #1;
        checks++;
        if ({stall_if, busy} !== 2'b10) begin
            errors++; $display("FAIL if_read_t0: stall_if,busy got %b expected 10", {stall_if, busy});
        end
        tick();
        checks++;
        if ({ram_en, ram_we, ram_addr, stall_if} !== {1'b1, 1'b0, 32'h0040, 1'b1}) begin
            errors++; $display("FAIL if_read_issue: got en=%b we=%b addr=%h stall=%b expected 1 0 00000040 1", ram_en, ram_we, ram_addr, stall_if);
        end
        tick();
        checks++;
        if ({ram_en, if_ready, stall_if} !== 3'b001) begin
            errors++; $display("FAIL if_read_t2: en,rdy,stall got %b expected 001", {ram_en, if_ready, stall_if});
        end
        tick();
        checks++;
        if ({if_ready, stall_if, if_rdata} !== {1'b1, 1'b0, 32'hDEADBEEF}) begin
            errors++; $display("FAIL if_read_done: rdy=%b stall=%b data=%h expected 1 0 deadbeef", if_ready, stall_if, if_rdata);
        end
        if_req = 1'b0;
        tick();
        checks++;
        if ({if_ready, busy, if_rdata} !== {2'b00, 32'hDEADBEEF}) begin
            errors++; $display("FAIL if_read_hold: rdy=%b busy=%b data=%h expected 0 0 deadbeef", if_ready, busy, if_rdata);
        end
    endtask

    task automatic test_write();
        tick();
        d_we = 1'b1; d_addr = 32'h1003; d_wdata = 32'h12345678; d_req = 1'b1;
        #1;
        checks++;
        if (stall_mem !== 1'b1) begin
            errors++; $display("FAIL write_stall_mem: got %b expected 1", stall_mem);
        end
        tick();
        checks++;
        if ({ram_en, ram_we, ram_addr, ram_wdata} !== {1'b1, 1'b1, 32'h1000, 32'h12345678}) begin
            errors++; $display("FAIL write_issue: en=%b we=%b addr=%h wdata=%h expected 1 1 00001000 12345678", ram_en, ram_we, ram_addr, ram_wdata);
        end
        if_addr = 32'h0080; if_req = 1'b1;
        tick();
        checks++;
        if ({d_ready, ram_en, if_ready, d_rdata} !== {3'b100, 32'h0}) begin
            errors++; $display("FAIL write_done: drdy,en,ifrdy=%b d_rdata=%h expected 100 0", {d_ready, ram_en, if_ready}, d_rdata);
        end
        d_req = 1'b0; d_we = 1'b0;
        ref_mem[32'h1000 >> 2] = 32'h12345678;
        tick();
        checks++;
        if ({ram_en, busy} !== 2'b00) begin
            errors++; $display("FAIL write_idle_gap: en,busy got %b expected 00", {ram_en, busy});
        end
        tick();
        checks++;
        if ({ram_en, ram_we, ram_addr} !== {2'b10, 32'h0080}) begin
            errors++; $display("FAIL write_then_if_issue: en=%b we=%b addr=%h expected 1 0 00000080", ram_en, ram_we, ram_addr);
        end
        tick(); tick();
        checks++;
        if ({if_ready, if_rdata} !== {1'b1, ref_mem[32]}) begin
            errors++; $display("FAIL write_then_if_done: rdy=%b data=%h expected 1 %h", if_ready, if_rdata, ref_mem[32]);
        end
        if_req = 1'b0;
        tick();
    endtask

    task automatic test_starvation();
        int own[$];
        int n_dready = 0;
        int dready_before_if = -1;
        int scnt = 0;
        bit ifp = 1'b1;
        int exp_own;
        tick();
        if_addr = 32'h0100; d_addr = 32'h0200; d_we = 1'b0;
        if_req = 1'b1; d_req = 1'b1;
        for (int c = 0; c < 80 && own.size() < 7; c++) begin
            tick();
            if (ram_en) own.push_back((ram_addr == 32'h0100) ? 0 : 1);
            if (d_ready) n_dready++;
            if (if_ready) begin
                dready_before_if = n_dready;
                if_req = 1'b0;
            end
        end
        d_req = 1'b0;
        checks++;
        if (own.size() != 7) begin
            errors++; $display("FAIL starve_grant_count: got %0d grants expected 7 within budget", own.size());
        end else begin
            for (int k = 0; k < 7; k++) begin
                exp_own = (ifp && scnt == SMAX) ? 0 : 1;
                if (exp_own == 0) begin
                    ifp = 1'b0; scnt = 0;
                end else begin
                    scnt = ifp ? ((scnt < SMAX) ? scnt + 1 : SMAX) : 0;
                end
                checks++;
                if (own[k] != exp_own) begin
                    errors++; $display("FAIL starve_grant_%0d: got owner %0d expected %0d (0=IF 1=D)", k, own[k], exp_own);
                end
            end
        end
        checks++;
        if (dready_before_if != SMAX) begin
            errors++; $display("FAIL starve_if_after_dready: got %0d d_ready pulses before if_ready expected %0d", dready_before_if, SMAX);
        end
        for (int c = 0; c < 20 && busy; c++) tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL starve_drain: busy got %b expected 0", busy);
        end
    endtask

    task automatic test_latency();
        int en_cnt = 0;
        int en_off = -1;
        int rdy_off = -1;
        logic [31:0] en_addr = '0;
        logic [31:0] got = '0;
        tick();
        if_addr3 = 32'h0302; if_req3 = 1'b1;
        for (int k = 0; k <= 7; k++) begin
            if (k > 0) tick();
            if (ram_en3) begin
                en_cnt++; en_off = k; en_addr = ram_addr3;
            end
            if (if_ready3) begin
                rdy_off = k; got = if_rdata3; if_req3 = 1'b0;
            end
        end
        checks++;
        if (en_cnt != 1 || en_off != 1) begin
            errors++; $display("FAIL lat3_ram_en: got %0d pulses at offset %0d expected 1 at offset 1", en_cnt, en_off);
        end
        checks++;
        if (en_addr !== 32'h0300) begin
            errors++; $display("FAIL lat3_addr_align: got %h expected 00000300", en_addr);
        end
        checks++;
        if (rdy_off != 2 + LAT3) begin
            errors++; $display("FAIL lat3_ready_cycle: got offset %0d expected %0d", rdy_off, 2 + LAT3);
        end
        checks++;
        if (got !== 32'h0300C0DE) begin
            errors++; $display("FAIL lat3_rdata: got %h expected 0300c0de", got);
        end
        checks++;
        if ({d_ready3, d_rdata3, ram_we3, ram_wdata3, stall_mem3, stall_if3, busy3} !== 69'h0) begin
            errors++; $display("FAIL lat3_quiet: got %h expected 0", {d_ready3, d_rdata3, ram_we3, ram_wdata3, stall_mem3, stall_if3, busy3});
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] rdy_pat = '0;
        logic [3:0] en_pat = '0;
        tick();
        if_addr = 32'h0040; if_req = 1'b1;
        tick(); tick();
        checks++;
        if ({busy, ram_en} !== 2'b10) begin
            errors++; $display("FAIL rstmid_in_wait: busy,en got %b expected 10", {busy, ram_en});
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({ram_en, busy, if_ready, d_ready, if_rdata} !== 36'h0) begin
            errors++; $display("FAIL rstmid_async: en,busy,rdy got %b if_rdata %h expected 0", {ram_en, busy, if_ready, d_ready}, if_rdata);
        end
        tick();
        reset = 1'b0;
        for (int k = 0; k <= 3; k++) begin
            if (k > 0) tick();
            rdy_pat[k] = if_ready;
            en_pat[k]  = ram_en;
        end
        checks++;
        if ({rdy_pat, en_pat} !== 8'b1000_0010) begin
            errors++; $display("FAIL rstmid_regrant: ready %b en %b expected 1000 0010", rdy_pat, en_pat);
        end
        checks++;
        if (if_rdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL rstmid_rdata: got %h expected deadbeef", if_rdata);
        end
        if_req = 1'b0;
        tick();
    endtask

    task automatic test_ready_rerequest();
        int c = 0;
        bit seen = 1'b0;
        tick();
        d_addr = 32'h0204; d_we = 1'b0; d_req = 1'b1;
        while (!d_ready && c < 20) begin
            tick(); c++;
        end
        checks++;
        if ({d_ready, d_rdata} !== {1'b1, ref_mem[32'h81]}) begin
            errors++; $display("FAIL rereq_first: rdy=%b data=%h expected 1 %h", d_ready, d_rdata, ref_mem[32'h81]);
        end
        tick();
        d_req = 1'b0;
        checks++;
        if ({ram_en, busy, d_ready} !== 3'b000) begin
            errors++; $display("FAIL rereq_no_dup: en,busy,rdy got %b expected 000", {ram_en, busy, d_ready});
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            seen = seen | ram_en | busy;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++; $display("FAIL rereq_quiet: activity %b expected 0", seen);
        end
        d_req = 1'b1;
        tick();
        checks++;
        if ({ram_en, ram_addr} !== {1'b1, 32'h0204}) begin
            errors++; $display("FAIL rereq_second: en=%b addr=%h expected 1 00000204", ram_en, ram_addr);
        end
        c = 0;
        while (!d_ready && c < 20) begin
            tick(); c++;
        end
        d_req = 1'b0;
        tick();
    endtask

    task automatic test_random();
        int en_at = -10;
        int rdy_at = -10;
        int scnt = 0;
        bit own_d = 1'b0;
        bit gi;
        bit exp_we = 1'b0;
        logic [31:0] exp_addr = '0, exp_wdata = '0, exp_rd = '0;
        logic [31:0] exp_ifr = '0, exp_dr = '0;
        reset = 1'b1; if_req = 1'b0; d_req = 1'b0;
        tick();
        reset = 1'b0;
        for (int c = 0; c < 600; c++) begin
            tick();
            checks++;
            if ({ram_en, if_ready, d_ready, busy} !==
                {c == en_at, c == rdy_at && !own_d, c == rdy_at && own_d, c >= en_at && c <= rdy_at}) begin
                errors++; $display("FAIL rand_ctrl c=%0d: en,ifr,dr,busy got %b expected %b", c, {ram_en, if_ready, d_ready, busy},
                    {c == en_at, c == rdy_at && !own_d, c == rdy_at && own_d, c >= en_at && c <= rdy_at});
            end
            if (c == en_at) begin
                checks++;
                if ({ram_we, ram_addr} !== {exp_we, exp_addr & ~32'h3} || (exp_we && ram_wdata !== exp_wdata)) begin
                    errors++; $display("FAIL rand_issue c=%0d: we=%b addr=%h wdata=%h expected %b %h %h", c, ram_we, ram_addr, ram_wdata,
                        exp_we, exp_addr & ~32'h3, exp_wdata);
                end
            end
            if (c == rdy_at && !exp_we) begin
                if (own_d) exp_dr = exp_rd; else exp_ifr = exp_rd;
            end
            checks++;
            if ({if_rdata, d_rdata} !== {exp_ifr, exp_dr}) begin
                errors++; $display("FAIL rand_rdata c=%0d: if=%h d=%h expected %h %h", c, if_rdata, d_rdata, exp_ifr, exp_dr);
            end
            if (c == rdy_at) begin
                if (own_d) d_req = 1'b0; else if_req = 1'b0;
            end else begin
                if (!if_req && $urandom_range(0, 2) == 0) begin
                    if_req = 1'b1; if_addr = $urandom_range(0, 65535);
                end
                if (!d_req && $urandom_range(0, 2) == 0) begin
                    d_req = 1'b1; d_we = $urandom_range(0, 1);
                    d_addr = $urandom_range(0, 65535); d_wdata = $urandom;
                end
            end
            if (c > rdy_at && (if_req || d_req)) begin
                gi = if_req && (!d_req || scnt == SMAX);
                own_d = !gi;
                if (gi) scnt = 0;
                else scnt = if_req ? ((scnt < SMAX) ? scnt + 1 : SMAX) : 0;
                exp_addr  = gi ? if_addr : d_addr;
                exp_we    = gi ? 1'b0 : d_we;
                exp_wdata = d_wdata;
                en_at  = c + 1;
                rdy_at = exp_we ? c + 2 : c + 2 + LAT1;
                if (exp_we) ref_mem[exp_addr[15:2]] = exp_wdata;
                else exp_rd = ref_mem[exp_addr[15:2]];
            end
        end
        for (int c = 0; c < 20 && (busy || if_req || d_req); c++) begin
            tick();
            if (if_ready) if_req = 1'b0;
            if (d_ready) d_req = 1'b0;
        end
        checks++;
        if ({busy, if_req, d_req} !== 3'b000) begin
            errors++; $display("FAIL rand_drain: busy,if_req,d_req got %b expected 000", {busy, if_req, d_req});
        end
    endtask

    initial begin
        reset = 1'b1;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        if_req3 = 1'b0; if_addr3 = '0;
        d_req3 = 1'b0; d_we3 = 1'b0; d_addr3 = '0; d_wdata3 = '0;
        for (int i = 0; i < 16384; i++) ref_mem[i] = ram_init(i);
        test_reset();
        test_if_read();
        test_write();
        test_starvation();
        test_latency();
        test_reset_mid();
        test_ready_rerequest();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
